// File: rtl/img_ram_arb_pkg.sv
// Shared constants and FSM encoding for the image RAM arbiter.
package img_ram_arb_pkg;

    localparam int unsigned IMG_WIDTH  = 128;
    localparam int unsigned IMG_HEIGHT = 96;
    localparam int unsigned IMG_DEPTH  = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned DATA_W     = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } arb_state_e;

endpackage

// File: rtl/img_ram_arb_rd_pipe.sv
// Two-stage read return path: RAM latency stage followed by a registered output stage.
module img_rd_pipe
    import img_ram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_oor,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data
);

    logic              r_req_s1;
    logic              r_oor_s1;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_s1   <= 1'b0;
            r_oor_s1   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_req_s1   <= i_req;
            r_oor_s1   <= i_oor;
            r_rd_valid <= r_req_s1;
            // Out-of-range reads still hit the RAM but their data is masked here.
            r_rd_data  <= (r_req_s1 && !r_oor_s1) ? i_ram_rdata : '0;
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/img_ram_arb.sv
// Single-port image RAM arbiter: display reads have strict priority over loader writes.
module img_ram_arb
    import img_ram_arb_pkg::*;
#(
    parameter int unsigned WIDTH  = IMG_WIDTH,
    parameter int unsigned HEIGHT = IMG_HEIGHT,
    parameter int unsigned DEPTH  = WIDTH * HEIGHT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    input  logic              i_load_start,
    output logic              o_load_done,
    output logic              o_wr_err,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

    arb_state_e        r_state;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic              r_wr_err;
    logic              r_load_done;

    logic w_wr_ready;
    logic w_wr_acc;
    logic w_wr_in_range;
    logic w_rd_oor;

    assign w_wr_ready    = (r_state == StLoad) && !i_rd_req;
    // load_start wins over a same-cycle write; nothing is written while reset is asserted.
    assign w_wr_acc      = i_wr_valid && w_wr_ready && !i_load_start && !rst;
    assign w_wr_in_range = (i_wr_addr < DEPTH_L);
    assign w_rd_oor      = (i_rd_addr >= DEPTH_L);

    always_comb begin
        o_ram_en    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = i_rd_addr;
        o_ram_wdata = i_wr_data;
        if (i_rd_req) begin
            o_ram_en = 1'b1;
        end else if (w_wr_acc) begin
            o_ram_en   = 1'b1;
            o_ram_we   = w_wr_in_range;
            o_ram_addr = i_wr_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_wr_cnt    <= '0;
            r_wr_err    <= 1'b0;
            r_load_done <= 1'b0;
        end else if (i_load_start) begin
            r_state     <= StLoad;
            r_wr_cnt    <= '0;
            r_wr_err    <= 1'b0;
            r_load_done <= 1'b0;
        end else if (w_wr_acc) begin
            if (!w_wr_in_range) begin
                r_wr_err <= 1'b1;
            end
            if (r_wr_cnt != DEPTH_L) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (r_wr_cnt == LAST_L) begin
                r_state     <= StDone;
                r_load_done <= 1'b1;
            end
        end
    end

    img_rd_pipe u_rd_pipe (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_rd_req),
        .i_oor       (w_rd_oor),
        .i_ram_rdata (i_ram_rdata),
        .o_rd_valid  (o_rd_valid),
        .o_rd_data   (o_rd_data)
    );

    assign o_wr_ready  = w_wr_ready;
    assign o_load_done = r_load_done;
    assign o_wr_err    = r_wr_err;

endmodule
